// File: rtl/aes_pkg.sv
// Shared parameters and types for the AES line unpacker.
package aes_pkg;

  localparam int LINE_W_DEF = 4096;
  localparam int BLK_W_DEF  = 128;
  localparam int NBLK_DEF   = LINE_W_DEF / BLK_W_DEF;
  localparam int IDX_W_DEF  = $clog2(NBLK_DEF);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  typedef logic [BLK_W_DEF-1:0] blk_t;

  // A one-block line still needs a 1-bit index port.
  function automatic int idx_width(input int nblk);
    return (nblk > 1) ? $clog2(nblk) : 1;
  endfunction

endpackage

// File: rtl/aes_blk_mux.sv
// Selects block sel_i from a line; block 0 is the most-significant slice.
module aes_blk_mux
  import aes_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int BLK_W  = BLK_W_DEF,
  localparam int NBLK  = LINE_W / BLK_W,
  localparam int IDX_W = idx_width(NBLK)
) (
  input  logic [LINE_W-1:0] line_i,
  input  logic [IDX_W-1:0]  sel_i,
  output logic [BLK_W-1:0]  blk_o
);

  always_comb begin
    blk_o = '0;
    for (int k = 0; k < NBLK; k++) begin
      if (sel_i == IDX_W'(k)) blk_o = line_i[LINE_W-1-k*BLK_W -: BLK_W];
    end
  end

endmodule

// File: rtl/aes_line_unpacker.sv
// Holds one fetched line and streams it out as BLK_W-bit blocks, MSB block first.
module aes_line_unpacker
  import aes_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int BLK_W  = BLK_W_DEF,
  localparam int NBLK  = LINE_W / BLK_W,
  localparam int IDX_W = idx_width(NBLK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_valid,
  output logic              line_ready,
  input  logic [LINE_W-1:0] line_data,
  input  logic              flush,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [BLK_W-1:0]  blk_data,
  output logic [IDX_W-1:0]  blk_idx,
  output logic              blk_last,
  output logic              busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBLK - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [BLK_W-1:0]  blk_data_q, blk_data_d;
  logic [IDX_W-1:0]  blk_idx_q, blk_idx_d;
  logic              blk_last_q, blk_last_d;
  logic              blk_hs, line_hs;

  assign blk_valid = (state_q == STREAM);
  assign busy      = (state_q == STREAM);
  assign blk_hs    = blk_valid & blk_ready;
  assign line_hs   = line_valid & line_ready;

  // A new line may only land on the final block handshake, giving gap-free back-to-back lines.
  always_comb begin
    line_ready = 1'b0;
    if (!flush) begin
      if (state_q == IDLE) line_ready = 1'b1;
      else                 line_ready = blk_hs & blk_last_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (line_hs) begin
      line_d  = line_data;
      cnt_d   = '0;
      state_d = STREAM;
    end else if (blk_hs) begin
      if (cnt_q != LAST_IDX) cnt_d = cnt_q + 1'b1;
      else                   state_d = IDLE;
    end
  end

  // Output registers follow the next count so data, index and last move together.
  aes_blk_mux #(
    .LINE_W (LINE_W),
    .BLK_W  (BLK_W)
  ) u_blk_mux (
    .line_i (line_d),
    .sel_i  (cnt_d),
    .blk_o  (blk_data_d)
  );

  assign blk_idx_d  = cnt_d;
  assign blk_last_d = (cnt_d == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      line_q     <= '0;
      blk_data_q <= '0;
      blk_idx_q  <= '0;
      blk_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      blk_data_q <= blk_data_d;
      blk_idx_q  <= blk_idx_d;
      blk_last_q <= blk_last_d;
    end
  end

  assign blk_data = blk_data_q;
  assign blk_idx  = blk_idx_q;
  assign blk_last = blk_last_q;

endmodule

// File: tb/tb_aes_line_unpacker.sv
// Directed bench for aes_line_unpacker at the default 4096/128 geometry.
module tb_aes_line_unpacker;

  localparam int LINE_W = 4096;
  localparam int BLK_W  = 128;
  localparam int NBLK   = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              line_valid;
  logic              line_ready;
  logic [LINE_W-1:0] line_data;
  logic              flush;
  logic              blk_valid;
  logic              blk_ready;
  logic [BLK_W-1:0]  blk_data;
  logic [4:0]        blk_idx;
  logic              blk_last;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  aes_line_unpacker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .line_data  (line_data),
    .flush      (flush),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .blk_data   (blk_data),
    .blk_idx    (blk_idx),
    .blk_last   (blk_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [BLK_W-1:0] pat_blk(input int k);
    logic [7:0] b;
    b = 8'(k);
    return {16{b}};
  endfunction

  function automatic logic [LINE_W-1:0] pat_line();
    logic [LINE_W-1:0] l;
    for (int k = 0; k < NBLK; k++) l[LINE_W-1-k*BLK_W -: BLK_W] = pat_blk(k);
    return l;
  endfunction

  task automatic drain();
    int guard;
    guard = 0;
    line_valid = 1'b0;
    blk_ready  = 1'b1;
    flush      = 1'b0;
    @(negedge clk);
    while (blk_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (blk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_timeout blk_valid=%b required 0", blk_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; line_valid = 1'b0; line_data = '0; flush = 1'b0; blk_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({blk_valid, busy, blk_last, line_ready} !== 4'b0001 || blk_idx !== 5'd0 || blk_data !== '0) begin
      n_fail++;
      $display("FAIL reset_values valid=%b busy=%b last=%b ready=%b idx=%0d required 0 0 0 1 0", blk_valid, busy, blk_last, line_ready, blk_idx);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stream();
    line_data = pat_line(); line_valid = 1'b1; blk_ready = 1'b1;
    n_tests++;
    if (line_ready !== 1'b1) begin n_fail++; $display("FAIL stream_idle_ready line_ready=%b required 1", line_ready); end
    for (int k = 0; k < NBLK; k++) begin
      @(negedge clk);
      line_valid = 1'b0;
      n_tests++;
      if (blk_valid !== 1'b1 || blk_idx !== 5'(k) || blk_data !== pat_blk(k) || blk_last !== (k == NBLK-1)) begin
        n_fail++;
        $display("FAIL stream_blk k=%0d valid=%b idx=%0d last=%b data=%h required idx=%0d data=%h", k, blk_valid, blk_idx, blk_last, blk_data, k, pat_blk(k));
      end
      n_tests++;
      if (line_ready !== (k == NBLK-1)) begin n_fail++; $display("FAIL stream_line_ready k=%0d line_ready=%b", k, line_ready); end
    end
    @(negedge clk);
    n_tests++;
    if (blk_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stream_end valid=%b busy=%b required 0 0", blk_valid, busy); end
  endtask

  task automatic test_stall();
    logic [3:0] pat;
    logic [BLK_W-1:0] prev_data;
    logic [4:0] prev_idx;
    logic prev_stall;
    int got, cyc;
    pat = 4'b1001;
    got = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0; prev_idx = '0;
    line_data = pat_line(); line_valid = 1'b1; blk_ready = 1'b0;
    @(negedge clk);
    line_valid = 1'b0;
    while (got < NBLK && cyc < 200) begin
      blk_ready = pat[3 - (cyc % 4)];
      if (prev_stall) begin
        n_tests++;
        if (blk_data !== prev_data || blk_idx !== prev_idx) begin
          n_fail++;
          $display("FAIL stall_stable idx=%0d data=%h required idx=%0d data=%h", blk_idx, blk_data, prev_idx, prev_data);
        end
      end
      if (blk_valid && blk_ready) begin
        n_tests++;
        if (blk_idx !== 5'(got) || blk_data !== pat_blk(got)) begin
          n_fail++;
          $display("FAIL stall_blk idx=%0d data=%h required idx=%0d data=%h", blk_idx, blk_data, got, pat_blk(got));
        end
        got++;
      end
      prev_stall = blk_valid && !blk_ready;
      prev_data = blk_data; prev_idx = blk_idx;
      cyc++;
      @(negedge clk);
    end
    n_tests++;
    if (got !== NBLK || blk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_count handshakes=%0d valid=%b required %0d 0", got, blk_valid, NBLK);
    end
  endtask

  task automatic test_back_to_back();
    logic [BLK_W-1:0] exp;
    line_data = {(LINE_W/8){8'hAA}}; line_valid = 1'b1; blk_ready = 1'b1;
    for (int c = 0; c < 2*NBLK; c++) begin
      @(negedge clk);
      if (c == 0) line_data = {(LINE_W/8){8'hBB}};
      if (c == NBLK) line_valid = 1'b0;
      exp = (c < NBLK) ? {16{8'hAA}} : {16{8'hBB}};
      n_tests++;
      if (blk_valid !== 1'b1 || blk_idx !== 5'(c % NBLK) || blk_data !== exp) begin
        n_fail++;
        $display("FAIL b2b_blk c=%0d valid=%b idx=%0d data=%h required idx=%0d data=%h", c, blk_valid, blk_idx, blk_data, c % NBLK, exp);
      end
      n_tests++;
      if (line_ready !== ((c % NBLK) == NBLK-1)) begin
        n_fail++;
        $display("FAIL b2b_line_ready c=%0d line_ready=%b", c, line_ready);
      end
    end
    @(negedge clk);
    n_tests++;
    if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end valid=%b required 0", blk_valid); end
  endtask

  task automatic test_flush();
    line_data = pat_line(); line_valid = 1'b1; blk_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      line_valid = 1'b0;
      if (k == 7) blk_ready = 1'b0;
    end
    @(negedge clk);
    n_tests++;
    if (blk_idx !== 5'd7 || blk_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre idx=%0d valid=%b required 7 1", blk_idx, blk_valid); end
    flush = 1'b1; line_valid = 1'b1; line_data = {(LINE_W/8){8'hEE}};
    #1;
    n_tests++;
    if (line_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready_low line_ready=%b required 0", line_ready); end
    @(negedge clk);
    flush = 1'b0; line_valid = 1'b0;
    #1;
    n_tests++;
    if (blk_valid !== 1'b0 || busy !== 1'b0 || line_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_after valid=%b busy=%b line_ready=%b required 0 0 1", blk_valid, busy, line_ready);
    end
    line_data = pat_line(); line_valid = 1'b1; blk_ready = 1'b1;
    @(negedge clk);
    line_valid = 1'b0;
    n_tests++;
    if (blk_valid !== 1'b1 || blk_idx !== 5'd0 || blk_data !== pat_blk(0)) begin
      n_fail++;
      $display("FAIL flush_restart valid=%b idx=%0d data=%h required 1 0 %h", blk_valid, blk_idx, blk_data, pat_blk(0));
    end
    drain();
  endtask

  task automatic test_async_reset();
    line_data = pat_line(); line_valid = 1'b1; blk_ready = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      line_valid = 1'b0;
    end
    n_tests++;
    if (blk_idx !== 5'd12) begin n_fail++; $display("FAIL areset_pre idx=%0d required 12", blk_idx); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({blk_valid, busy, blk_last, line_ready} !== 4'b0001 || blk_idx !== 5'd0 || blk_data !== '0) begin
      n_fail++;
      $display("FAIL areset_values valid=%b busy=%b last=%b ready=%b idx=%0d data=%h", blk_valid, busy, blk_last, line_ready, blk_idx, blk_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    line_data = pat_line(); line_valid = 1'b1; blk_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      line_valid = 1'b0;
      n_tests++;
      if (blk_valid !== 1'b1 || blk_idx !== 5'(k) || blk_data !== pat_blk(k)) begin
        n_fail++;
        $display("FAIL areset_restart k=%0d idx=%0d data=%h required %0d %h", k, blk_idx, blk_data, k, pat_blk(k));
      end
    end
    drain();
  endtask

  task automatic test_hold_no_overwrite();
    int bad_rdy, bad_idx;
    bad_rdy = 0; bad_idx = 0;
    line_data = pat_line(); line_valid = 1'b1; blk_ready = 1'b0;
    @(negedge clk);
    line_data = {(LINE_W/8){8'hFF}};
    for (int c = 0; c < 100; c++) begin
      if (line_ready !== 1'b0) bad_rdy++;
      if (blk_idx !== 5'd0) bad_idx++;
      @(negedge clk);
    end
    n_tests++;
    if (bad_rdy != 0) begin n_fail++; $display("FAIL hold_line_ready cycles_high=%0d required 0", bad_rdy); end
    n_tests++;
    if (bad_idx != 0) begin n_fail++; $display("FAIL hold_idx cycles_nonzero=%0d required 0", bad_idx); end
    line_valid = 1'b0; blk_ready = 1'b1;
    for (int k = 0; k < NBLK; k++) begin
      n_tests++;
      if (blk_valid !== 1'b1 || blk_idx !== 5'(k) || blk_data !== pat_blk(k)) begin
        n_fail++;
        $display("FAIL hold_data k=%0d idx=%0d data=%h required %0d %h", k, blk_idx, blk_data, k, pat_blk(k));
      end
      @(negedge clk);
    end
    n_tests++;
    if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL hold_end valid=%b required 0", blk_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_hold_no_overwrite();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes_line_unpacker.md
Name: aes_line_unpacker

Overview:
- Sits directly downstream of the fetch stage in the AES datapath.
- Accepts one wide line (default 4096 bits) per valid/ready handshake, holds it in a local line register, and emits it as a stream of 128-bit AES blocks.
- Each emitted block carries its index and a last-of-line flag, so the AES core can consume one state per handshake without seeing the line width.

Parameters:
- LINE_W, 4096, width of a fetched line in bits; must be an integer multiple of BLK_W.
- BLK_W, 128, width of one AES block in bits.
- NBLK, LINE_W/BLK_W (32), blocks per line; derived, not overridable.
- IDX_W, $clog2(NBLK) (5), width of the block index.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- line_valid  input  1  fetch stage presents a line.
- line_ready  output  1  unpacker will accept a line this cycle.
- line_data  input  LINE_W  fetched line, MSB-first byte order.
- flush  input  1  synchronous abort; discards the current line.
- blk_valid  output  1  block output valid.
- blk_ready  input  1  AES core accepts the block.
- blk_data  output  BLK_W  current block.
- blk_idx  output  IDX_W  index of the block within its line.
- blk_last  output  1  high when blk_idx == NBLK-1.
- busy  output  1  high whenever a line is held (state STREAM).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, cnt=0, line register cleared.
- Reset values of outputs: blk_valid=0, blk_data=0, blk_idx=0, blk_last=0, busy=0, line_ready=1.
- Reset mid-line: the held line is discarded; no partial resumption.
- States:
  - IDLE: line_ready=1, blk_valid=0. Line handshake (line_valid & line_ready) captures line_data and sets cnt=0 -> STREAM.
  - STREAM: blk_valid=1, busy=1.
- Block selection: blk_data = line register bits [LINE_W-1-cnt*BLK_W -: BLK_W], so block 0 is the most-significant 128 bits.
- Output registering: blk_data, blk_idx and blk_last are registered. blk_data, blk_idx and blk_last are all updated on the same edge that advances cnt (or, for block 0, on the line-capture edge).
- Latency: a line accepted at edge N gives blk_valid=1 with block 0 from edge N onward, i.e. visible in cycle N+1.
- Block handshake in STREAM (blk_valid & blk_ready):
  - If cnt < NBLK-1: cnt increments and the next block is presented on the following cycle.
  - If cnt == NBLK-1 and line_valid=0: go to IDLE, blk_valid drops next cycle.
  - If cnt == NBLK-1 and line_valid=1: back-to-back case; the new line is captured at the same edge, cnt=0, state stays STREAM, and there is no bubble.
- line_ready in STREAM: equals blk_valid & blk_ready & blk_last, which is combinational from blk_ready.
- Backpressure: while blk_ready=0, blk_data, blk_idx and blk_last hold stable; a line is never accepted mid-stream.
- Throughput: one block per cycle at full blk_ready. Sustained rate is one line per NBLK cycles.
- flush:
  - Highest priority; state goes to IDLE and cnt=0 on the next edge, blk_valid=0 next cycle.
  - line_ready is forced 0 during the flush cycle, so no line is captured.
  - A block handshake in the same cycle still counts as consumed, but no further blocks issue.
- Index arithmetic: cnt is IDX_W bits and never wraps past NBLK-1; wrap to 0 happens only on line capture or flush.

Decomposition:
- Shared package aes_pkg holds:
  - LINE_W and BLK_W defaults.
  - NBLK and IDX_W derivations.
  - The state typedef (IDLE, STREAM).
  - A blk_t typedef (logic [BLK_W-1:0]).
- One sub-module, aes_blk_mux: combinational selection of block cnt from the line register, instantiated once.
- All sequencing stays in aes_line_unpacker.

Test Plan:
- Reset release, then a line whose block k = {16{8'(k)}}, with blk_ready=1 -> 32 consecutive blocks, block k = 0x0000..00 through 0x1F1F..1F, blk_last only on idx 31, blk_valid low in the cycle after.
- Same line with blk_ready toggling 1,0,0,1 -> no block duplicated or skipped, data stable while stalled, 32 handshakes total.
- Two lines presented continuously (A = all 0xAA, B = all 0xBB) -> line_ready pulses exactly on A's idx-31 handshake, B idx 0 follows A idx 31 with no gap, 64 blocks in 64 cycles.
- flush asserted while blk_idx=7 and stalled -> blk_valid=0 next cycle, busy=0, line_ready=1. A following line restarts at idx 0.
- rst_n pulsed low asynchronously (between edges) at idx 12 -> outputs return to reset values immediately. After release, the next line streams from idx 0 with correct data.
- line_valid held high with blk_ready=0 for 100 cycles -> line_ready stays 0, idx stays 0, and the line register is not overwritten.
